mips_seq_alu: RTL and testbench

//  Parametrised multi-cycle execute unit for the MIPS datapath: single-cycle logic/arith/shift/compare/CLZ/CLO

---
 rtl/mips_alu_pkg.sv | 37 +++
 rtl/mips_seq_mult_core.sv | 63 ++++++
 rtl/mips_seq_alu.sv | 147 ++++++++++++++
 tb/tb_mips_seq_alu.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared types for the MIPS sequential execute unit: opcode and FSM encodings,
// plus the classifier that routes an opcode to the iterative multiplier.
package mips_alu_pkg;

   typedef enum logic [4:0] {
      OpAdd,
      OpAddu,
      OpSub,
      OpSubu,
      OpAnd,
      OpOr,
      OpXor,
      OpNor,
      OpSlt,
      OpSltu,
      OpSll,
      OpSrl,
      OpSra,
      OpClz,
      OpClo,
      OpMult,
      OpMultu,
      OpMfhi,
      OpMflo
   } alu_op_t;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDone
   } state_t;

   function automatic logic is_multi_cycle(logic [4:0] op);
      return (op == OpMult) || (op == OpMultu);
   endfunction

endpackage

// File: rtl/mips_seq_mult_core.sv
// Iterative shift-add multiplier: WIDTH steps on operand magnitudes, then a
// two's-complement fix-up when exactly one signed operand was negative.
module mips_seq_mult_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signedOp,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned IterW = $clog2(WIDTH);

   logic                 busyQ;
   logic                 negQ;
   logic [IterW-1:0]     iterQ;
   logic [WIDTH-1:0]     mcandQ;
   logic [2*WIDTH-1:0]   accQ;
   logic [2*WIDTH-1:0]   accNext;
   logic [WIDTH:0]       partial;
   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;

   // Upper half accumulates the multiplicand, lower half shifts out multiplier bits.
   always_comb begin
      magA    = (signedOp && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      magB    = (signedOp && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      partial = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, mcandQ} : '0);
      accNext = {partial, accQ[WIDTH-1:1]};
      product = negQ ? (~accNext + (2*WIDTH)'(1)) : accNext;
   end

   assign busy = busyQ;
   assign done = busyQ && (iterQ == IterW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         busyQ  <= 1'b0;
         negQ   <= 1'b0;
         iterQ  <= '0;
         mcandQ <= '0;
         accQ   <= '0;
      end else if (start) begin
         busyQ  <= 1'b1;
         negQ   <= signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
         iterQ  <= '0;
         mcandQ <= magA;
         accQ   <= {{WIDTH{1'b0}}, magB};
      end else if (busyQ) begin
         accQ  <= accNext;
         iterQ <= iterQ + IterW'(1);
         if (done) begin
            busyQ <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mips_seq_alu.sv
// EX-stage execute unit: single-cycle ALU ops plus MULT/MULTU via the iterative
// core, with architectural HI/LO and valid/ready handshakes on both sides.
module mips_seq_alu
   import mips_alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t               stateQ, stateD;
   logic                 accept;
   logic                 multStart, multBusy, multDone;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     resultQ, hiQ, loQ;
   logic                 zeroQ, overflowQ;
   logic [WIDTH-1:0]     aluRes, sum, diff, scan, lead;
   logic                 aluOvf, aluZero, opDefined;
   logic [SHAMT_W-1:0]   shamt;

   assign in_ready  = !multBusy &&
                      ((stateQ == StIdle) || ((stateQ == StDone) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (stateQ == StDone);
   assign result    = resultQ;
   assign zero      = zeroQ;
   assign overflow  = overflowQ;
   assign hi        = hiQ;
   assign lo        = loQ;
   assign multStart = accept && is_multi_cycle(op);

   mips_seq_mult_core #(
      .WIDTH (WIDTH)
   ) u_mult (
      .clk      (clk),
      .reset    (reset),
      .start    (multStart),
      .signedOp (op == OpMult),
      .a        (a),
      .b        (b),
      .busy     (multBusy),
      .done     (multDone),
      .product  (product)
   );

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle: begin
            if (accept) stateD = is_multi_cycle(op) ? StMul : StDone;
         end
         StMul: begin
            if (multDone) stateD = StDone;
         end
         StDone: begin
            if (out_ready) begin
               if (accept) stateD = is_multi_cycle(op) ? StMul : StDone;
               else        stateD = StIdle;
            end
         end
         default: stateD = StIdle;
      endcase
   end

   // Leading-count scan: the highest set bit of the (optionally inverted) operand wins.
   always_comb begin
      scan = (op == OpClo) ? ~a : a;
      lead = WIDTH'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (scan[i]) lead = WIDTH'(WIDTH - 1 - i);
      end
   end

   always_comb begin
      aluRes    = '0;
      aluOvf    = 1'b0;
      opDefined = 1'b1;
      sum       = a + b;
      diff      = a - b;
      shamt     = b[SHAMT_W-1:0];
      case (op)
         OpAdd: begin
            aluRes = sum;
            aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OpAddu: aluRes = sum;
         OpSub: begin
            aluRes = diff;
            aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OpSubu:  aluRes = diff;
         OpAnd:   aluRes = a & b;
         OpOr:    aluRes = a | b;
         OpXor:   aluRes = a ^ b;
         OpNor:   aluRes = ~(a | b);
         OpSlt:   aluRes = WIDTH'($signed(a) < $signed(b));
         OpSltu:  aluRes = WIDTH'(a < b);
         OpSll:   aluRes = a << shamt;
         OpSrl:   aluRes = a >> shamt;
         OpSra:   aluRes = WIDTH'($signed(a) >>> shamt);
         OpClz:   aluRes = lead;
         OpClo:   aluRes = lead;
         OpMult:  aluRes = '0;
         OpMultu: aluRes = '0;
         OpMfhi:  aluRes = hiQ;
         OpMflo:  aluRes = loQ;
         default: opDefined = 1'b0;
      endcase
      aluZero = opDefined && (aluRes == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= StIdle;
         resultQ   <= '0;
         zeroQ     <= 1'b0;
         overflowQ <= 1'b0;
         hiQ       <= '0;
         loQ       <= '0;
      end else begin
         stateQ <= stateD;
         if (accept) begin
            resultQ   <= aluRes;
            zeroQ     <= aluZero;
            overflowQ <= aluOvf;
         end
         if (multDone) begin
            {hiQ, loQ} <= product;
         end
      end
   end

endmodule

// File: tb/tb_mips_seq_alu.sv
// Self-checking bench for mips_seq_alu: directed table, multi-cycle corner
// sequences, randomized ops against an arithmetic reference, and a 16-bit build.
module tb_mips_seq_alu;
   import mips_alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid, inReady, outValid, outReady, zero, ovf;
   logic [4:0]  op;
   logic [31:0] a, b, result, hi, lo;

   logic        inValid16, inReady16, outValid16, outReady16, zero16, ovf16;
   logic [4:0]  op16;
   logic [15:0] a16, b16, result16, hi16, lo16;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a, b, res;
      logic        z, v;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mips_seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady), .op(op),
      .a(a), .b(b), .out_valid(outValid), .out_ready(outReady), .result(result),
      .zero(zero), .overflow(ovf), .hi(hi), .lo(lo)
   );

   mips_seq_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(inValid16), .in_ready(inReady16), .op(op16),
      .a(a16), .b(b16), .out_valid(outValid16), .out_ready(outReady16), .result(result16),
      .zero(zero16), .overflow(ovf16), .hi(hi16), .lo(lo16)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference computed from the arithmetic meaning of each op.
   function automatic void refOp(input logic [4:0] o, input logic [31:0] x, y,
                                 inout logic [31:0] h, l,
                                 output logic [31:0] r, output logic z, v);
      longint      s;
      logic [63:0] p;
      int          n;
      r = '0;
      v = 1'b0;
      case (o)
         OpAdd:   begin r = x + y; s = longint'($signed(x)) + longint'($signed(y));
                        v = (s != longint'($signed(r))); end
         OpAddu:  r = x + y;
         OpSub:   begin r = x - y; s = longint'($signed(x)) - longint'($signed(y));
                        v = (s != longint'($signed(r))); end
         OpSubu:  r = x - y;
         OpAnd:   r = x & y;
         OpOr:    r = x | y;
         OpXor:   r = x ^ y;
         OpNor:   r = ~(x | y);
         OpSlt:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         OpSltu:  r = (x < y) ? 32'd1 : 32'd0;
         OpSll:   r = x << y[4:0];
         OpSrl:   r = x >> y[4:0];
         OpSra:   r = 32'($signed(x) >>> y[4:0]);
         OpClz:   begin n = 0; while (n < 32 && x[31-n] == 1'b0) n++; r = 32'(n); end
         OpClo:   begin n = 0; while (n < 32 && x[31-n] == 1'b1) n++; r = 32'(n); end
         OpMult:  begin p = 64'(longint'($signed(x)) * longint'($signed(y))); {h, l} = p; end
         OpMultu: begin p = {32'd0, x} * {32'd0, y}; {h, l} = p; end
         OpMfhi:  r = h;
         OpMflo:  r = l;
         default: r = '0;
      endcase
      z = (o <= 5'd18) && (r == '0);
   endfunction

   task automatic runOp(input logic [4:0] o, input logic [31:0] x, y,
                        output logic [31:0] r, output logic z, v, output int lat);
      int n = 0;
      @(negedge clk);
      op = o; a = x; b = y; inValid = 1'b1; outReady = 1'b1;
      #1;
      while (!inReady && n < 100) begin @(negedge clk); #1; n++; end
      check("issue_ready", inReady, 1'b1);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      lat = 1;
      while (!outValid && lat < 100) begin @(negedge clk); lat++; end
      r = result; z = zero; v = ovf;
   endtask

   task automatic runOp16(input logic [4:0] o, input logic [15:0] x, y,
                          output logic [15:0] r, output logic z, v, output int lat);
      int n = 0;
      @(negedge clk);
      op16 = o; a16 = x; b16 = y; inValid16 = 1'b1; outReady16 = 1'b1;
      #1;
      while (!inReady16 && n < 100) begin @(negedge clk); #1; n++; end
      check("issue_ready16", inReady16, 1'b1);
      @(posedge clk);
      @(negedge clk);
      inValid16 = 1'b0;
      lat = 1;
      while (!outValid16 && lat < 100) begin @(negedge clk); lat++; end
      r = result16; z = zero16; v = ovf16;
   endtask

   task automatic doAndCheck(input logic [4:0] o, input logic [31:0] x, y);
      logic [31:0] er, r;
      logic        ez, ev, z, v;
      int          lat;
      string       tag;
      tag = $sformatf("rand op%0d a=%0h b=%0h", o, x, y);
      refOp(o, x, y, mHi, mLo, er, ez, ev);
      runOp(o, x, y, r, z, v, lat);
      check({tag, " result"}, r, er);
      check({tag, " zero"}, z, ez);
      check({tag, " overflow"}, v, ev);
      check({tag, " latency"}, lat, is_multi_cycle(o) ? 33 : 1);
      check({tag, " hi"}, hi, mHi);
      check({tag, " lo"}, lo, mLo);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, ev;
      logic [15:0] r16;
      logic        z, v;
      int          lat, n, held, pulses;

      reset = 1'b1; inValid = 1'b0; outReady = 1'b0; op = '0; a = '0; b = '0;
      inValid16 = 1'b0; outReady16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset state", {inReady, outValid, zero, ovf, result, hi, lo},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0});
      check("reset state16", {inReady16, outValid16, result16, hi16, lo16},
            {1'b1, 1'b0, 16'd0, 16'd0, 16'd0});

      // Directed single-cycle table: {op, a, b, result, zero, overflow}
      vecs.push_back('{OpAdd,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1});
      vecs.push_back('{OpAddu, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0});
      vecs.push_back('{OpSub,  32'd5,        32'd5,        32'd0,        1'b1, 1'b0});
      vecs.push_back('{OpSub,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1});
      vecs.push_back('{OpSlt,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0});
      vecs.push_back('{OpSltu, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0});
      vecs.push_back('{OpSra,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0});
      vecs.push_back('{OpSll,  32'h00000001, 32'd32,       32'h00000001, 1'b0, 1'b0});
      vecs.push_back('{OpNor,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0});
      vecs.push_back('{OpClz,  32'd0,        32'd0,        32'd32,       1'b0, 1'b0});
      vecs.push_back('{OpClz,  32'h00010000, 32'd0,        32'd15,       1'b0, 1'b0});
      vecs.push_back('{OpClo,  32'hFFFFFFFF, 32'd0,        32'd32,       1'b0, 1'b0});
      vecs.push_back('{OpClo,  32'hF0000000, 32'd0,        32'd4,        1'b0, 1'b0});
      vecs.push_back('{OpClo,  32'hF0000000, 32'd0,        32'd4,        1'b0, 1'b0});
      vecs.push_back('{5'd25,  32'd5,        32'd5,        32'd0,        1'b0, 1'b0});
      for (int i = 0; i < vecs.size(); i++) begin
         runOp(vecs[i].op, vecs[i].a, vecs[i].b, r, z, v, lat);
         check($sformatf("vec%0d result", i), r, vecs[i].res);
         check($sformatf("vec%0d flags", i), {z, v}, {vecs[i].z, vecs[i].v});
         check($sformatf("vec%0d latency", i), lat, 1);
      end

      // MULT -3 * 7
      runOp(OpMult, 32'hFFFFFFFD, 32'd7, r, z, v, lat);
      check("mult latency", lat, 33);
      check("mult hi/lo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
      check("mult result/zero", {r, z, v}, {32'd0, 1'b1, 1'b0});
      mHi = 32'hFFFFFFFF; mLo = 32'hFFFFFFEB;

      // MULTU with MFHI queued behind it: held off during MUL, accepted in DONE
      @(negedge clk);
      op = OpMultu; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; inValid = 1'b1; outReady = 1'b1;
      @(negedge clk);
      op = OpMfhi; a = '0; b = '0;
      n = 1; held = 0;
      #1;
      while (!outValid && n < 100) begin
         if (inReady) held++;
         @(negedge clk); #1; n++;
      end
      check("multu latency", n, 33);
      check("mfhi held off during mul", held, 0);
      check("multu hi/lo", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
      check("done in_ready", inReady, 1'b1);
      @(negedge clk);
      inValid = 1'b0;
      check("mfhi back-to-back", {outValid, result, zero}, {1'b1, 32'hFFFFFFFE, 1'b0});
      mHi = 32'hFFFFFFFE; mLo = 32'h00000001;
      runOp(OpMflo, 32'd0, 32'd0, r, z, v, lat);
      check("mflo after multu", r, 32'h00000001);

      // Backpressure: ADD result held while SUB waits
      @(negedge clk);
      op = OpAdd; a = 32'd10; b = 32'd20; inValid = 1'b1; outReady = 1'b0;
      @(negedge clk);
      op = OpSub; a = 32'd100; b = 32'd1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("backpressure cycle%0d", k), {outValid, inReady, zero, ovf, result},
               {1'b1, 1'b0, 1'b0, 1'b0, 32'd30});
         @(negedge clk);
      end
      outReady = 1'b1;
      #1;
      check("release in_ready", inReady, 1'b1);
      @(negedge clk);
      inValid = 1'b0;
      check("op after release", {outValid, result}, {1'b1, 32'd99});

      // Reset at MUL iteration 10
      @(negedge clk);
      op = OpMult; a = 32'd123; b = 32'd456; inValid = 1'b1; outReady = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset mid-mul", {outValid, inReady, hi, lo, result},
            {1'b0, 1'b1, 32'd0, 32'd0, 32'd0});
      mHi = '0; mLo = '0;
      pulses = 0;
      repeat (40) begin @(negedge clk); if (outValid) pulses++; end
      check("no out_valid after abort", pulses, 0);

      // Randomized ops against the reference
      for (int i = 0; i < 150; i++) begin
         doAndCheck(5'($urandom_range(0, 21)), pickOperand(), pickOperand());
      end

      // 16-bit build
      runOp16(OpAdd, 16'h7FFF, 16'd1, r16, z, v, lat);
      check("w16 add overflow", {r16, z, v}, {16'h8000, 1'b0, 1'b1});
      runOp16(OpClz, 16'h0000, 16'd0, r16, z, v, lat);
      check("w16 clz zero", r16, 16'd16);
      runOp16(OpClz, 16'h0100, 16'd0, r16, z, v, lat);
      check("w16 clz", r16, 16'd7);
      runOp16(OpClo, 16'hFFFF, 16'd0, r16, z, v, lat);
      check("w16 clo ones", r16, 16'd16);
      runOp16(OpClo, 16'hF000, 16'd0, r16, z, v, lat);
      check("w16 clo", r16, 16'd4);
      runOp16(OpMult, 16'hFFFD, 16'd7, r16, z, v, lat);
      check("w16 mult latency", lat, 17);
      check("w16 mult hi/lo", {hi16, lo16, r16, z}, {16'hFFFF, 16'hFFEB, 16'd0, 1'b1});
      runOp16(OpMultu, 16'hFFFF, 16'hFFFF, r16, z, v, lat);
      check("w16 multu hi/lo", {hi16, lo16}, {16'hFFFE, 16'h0001});
      runOp16(OpMfhi, 16'd0, 16'd0, r16, z, v, lat);
      check("w16 mfhi", r16, 16'hFFFE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
